ch2_4demux_tdm: RTL and testbench

Clocked 1-to-4 time-division demultiplexer. It is the receive end of the CH2 4:1 mux channel.
- A serial stream carries one bit per time slot. Slot 0 is marked by SYNC.
- The block tracks the slot position, collects one bit per channel, and presents a full parallel frame on Z with a one-cycle VALID pulse.
- Sits downstream of the 4:1 mux path and feeds per-channel logic.

---
 rtl/ch2_pkg.sv | 31 +++
 rtl/ch2_slot_ctr.sv | 69 ++++++
 rtl/ch2_4demux_tdm.sv | 176 +++++++++++++++++
 tb/tb_ch2_4demux_tdm.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ch2_pkg.sv
// ---------------------------------------------------------------------------
// ch2_pkg
// Shared definitions for the CH2 receive-side TDM demultiplexer.
//   - FSM state encoding (HUNT / LOCKED)
//   - default channel count and slot-counter width
//   - number of extra slots per frame. This is 1 when CH2_4DEMUX_PARITY_EN
//     is defined, because a trailing even-parity slot is then added.
//   - even-parity helper over one frame of data bits
// ---------------------------------------------------------------------------
package ch2_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } ch2_state_e;

  localparam int CH2_N_CH   = 4;
  localparam int CH2_SLOT_W = 2;

`ifdef CH2_4DEMUX_PARITY_EN
  localparam int CH2_PAR_SLOTS = 1;
`else
  localparam int CH2_PAR_SLOTS = 0;
`endif

  // Even parity bit: the value that makes the total count of ones even.
  function automatic logic ch2_even_parity(input logic [CH2_N_CH-1:0] data);
    return ^data;
  endfunction

endpackage : ch2_pkg

// File: rtl/ch2_slot_ctr.sv
// ---------------------------------------------------------------------------
// ch2_slot_ctr
// Slot position counter for the CH2 demux.
// A frame is N_CH slots long. With CH2_4DEMUX_PARITY_EN it is N_CH+1 slots,
// and the counter grows by one bit.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset (counter -> 0)
//   en_i     advance by one slot, wrapping after the last slot
//   load1_i  synchronous load to 1 (slot 0 just consumed with SYNC)
//   clr_i    synchronous clear to 0 (highest priority)
//   slot_o   index of the next slot expected
//   tc_o     high while slot_o is the last slot of the frame
// ---------------------------------------------------------------------------
module ch2_slot_ctr
  import ch2_pkg::*;
#(
  parameter int N_CH   = CH2_N_CH,
  parameter int SLOT_W = CH2_SLOT_W
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              en_i,
  input  logic                              load1_i,
  input  logic                              clr_i,
  output logic [SLOT_W+CH2_PAR_SLOTS-1:0]   slot_o,
  output logic                              tc_o
);

  localparam int                 CNT_W = SLOT_W + CH2_PAR_SLOTS;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(N_CH + CH2_PAR_SLOTS - 1);
  localparam logic [CNT_W-1:0]   ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] slot_d;
  logic [CNT_W-1:0] slot_q;

  // Next slot index: clear beats load beats advance.
  // The wrap is explicit so that non-power-of-2 frame lengths also work.
  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = ZERO;
    end else if (load1_i) begin
      slot_d = ONE;
    end else if (en_i) begin
      if (slot_q == LAST) begin
        slot_d = ZERO;
      end else begin
        slot_d = slot_q + ONE;
      end
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot index register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= ZERO;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
  assign tc_o   = (slot_q == LAST);

endmodule : ch2_slot_ctr

// File: rtl/ch2_4demux_tdm.sv
// ---------------------------------------------------------------------------
// ch2_4demux_tdm
// Receive end of the CH2 4:1 TDM channel.
// The block takes one serial bit per slot strobe and locks onto SYNC, which
// marks slot 0. It collects one bit per channel and publishes each complete
// frame on Z, with a one-cycle VALID pulse.
// Optional build macro: CH2_4DEMUX_PARITY_EN. It appends an even-parity slot
// after the data slots; Z/VALID then update on that parity slot.
// Ports:
//   CLK    rising-edge clock
//   RST    asynchronous active-high reset
//   D      serial data bit for the current slot
//   EN     slot strobe; D and SYNC are only sampled when EN=1
//   SYNC   frame marker, high together with the slot-0 bit
//   Z      last complete frame, Z[i] = bit of slot i
//   VALID  one-cycle pulse when Z is updated
//   SLOT   index of the next slot expected
//   LOCK   1 while frame-locked
//   ERR    one-cycle pulse on a framing or parity error
// ---------------------------------------------------------------------------
module ch2_4demux_tdm
  import ch2_pkg::*;
#(
  parameter int N_CH   = CH2_N_CH,
  parameter int SLOT_W = CH2_SLOT_W
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              D,
  input  logic                              EN,
  input  logic                              SYNC,
  output logic [N_CH-1:0]                   Z,
  output logic                              VALID,
  output logic [SLOT_W+CH2_PAR_SLOTS-1:0]   SLOT,
  output logic                              LOCK,
  output logic                              ERR
);

  localparam int              CNT_W  = SLOT_W + CH2_PAR_SLOTS;
  localparam logic [N_CH-1:0] NZEROS = {N_CH{1'b0}};

  ch2_state_e       state_d;
  ch2_state_e       state_q;
  logic [N_CH-1:0]  staging_d;
  logic [N_CH-1:0]  staging_q;
  logic [N_CH-1:0]  z_d;
  logic [N_CH-1:0]  z_q;
  logic             valid_d;
  logic             valid_q;
  logic             err_d;
  logic             err_q;

  logic [CNT_W-1:0]  slot_s;
  logic [SLOT_W-1:0] slot_idx_s;
  logic              slot_zero_s;
  logic              ctr_tc_s;
  logic              ctr_adv_s;
  logic              ctr_load1_s;
  logic              ctr_clr_s;
  logic [N_CH-1:0]   merged_s;
  logic [N_CH-1:0]   first_s;

  ch2_slot_ctr #(
    .N_CH   (N_CH),
    .SLOT_W (SLOT_W)
  ) u_slot_ctr (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (ctr_adv_s),
    .load1_i (ctr_load1_s),
    .clr_i   (ctr_clr_s),
    .slot_o  (slot_s),
    .tc_o    (ctr_tc_s)
  );

  // The low bits are enough to address a data slot. A parity slot is never
  // written into staging.
  assign slot_idx_s  = slot_s[SLOT_W-1:0];
  assign slot_zero_s = (slot_s == {CNT_W{1'b0}});
  // Fresh frame contents when slot 0 is taken: only bit 0 is meaningful.
  assign first_s     = {{(N_CH-1){1'b0}}, D};

  // Frame FSM, staging update and output next-state.
  always_comb begin
    state_d     = state_q;
    staging_d   = staging_q;
    z_d         = z_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    ctr_adv_s   = 1'b0;
    ctr_load1_s = 1'b0;
    ctr_clr_s   = 1'b0;
    // Staging with the current bit dropped into its slot. On the last data
    // slot this is the complete frame.
    merged_s             = staging_q;
    merged_s[slot_idx_s] = D;

    case (state_q)
      ST_HUNT: begin
        if (EN && SYNC) begin
          staging_d   = first_s;
          ctr_load1_s = 1'b1;
          state_d     = ST_LOCKED;
        end else begin
          state_d = ST_HUNT;
        end
      end

      ST_LOCKED: begin
        if (!EN) begin
          state_d = ST_LOCKED;
        end else if (SYNC) begin
          // SYNC on slot 0 is the normal frame start. Anywhere else, the
          // partial frame is dropped and we resynchronise on this bit.
          err_d       = ~slot_zero_s;
          staging_d   = first_s;
          ctr_load1_s = 1'b1;
        end else if (slot_zero_s) begin
          // Slot 0 arrived without its marker: the lock is lost.
          err_d     = 1'b1;
          state_d   = ST_HUNT;
          staging_d = NZEROS;
          ctr_clr_s = 1'b1;
        end else if (ctr_tc_s) begin
`ifdef CH2_4DEMUX_PARITY_EN
          // D is the parity bit here. The data slots are already in staging.
          if (D == ch2_even_parity(staging_q)) begin
            z_d     = staging_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
`else
          z_d     = merged_s;
          valid_d = 1'b1;
`endif
          staging_d = NZEROS;
          ctr_clr_s = 1'b1;
        end else begin
          staging_d = merged_s;
          ctr_adv_s = 1'b1;
        end
      end

      default: begin
        state_d   = ST_HUNT;
        staging_d = NZEROS;
        ctr_clr_s = 1'b1;
      end
    endcase
  end

  // State, staging and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_HUNT;
      staging_q <= NZEROS;
      z_q       <= NZEROS;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      staging_q <= staging_d;
      z_q       <= z_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign Z     = z_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign SLOT  = slot_s;
  assign LOCK  = (state_q == ST_LOCKED);

endmodule : ch2_4demux_tdm

// File: tb/tb_ch2_4demux_tdm.sv
// ---------------------------------------------------------------------------
// tb_ch2_4demux_tdm
// Directed bench for ch2_4demux_tdm. A frame-level reference model keeps
// the bits received so far in a queue. Every driven cycle is compared
// against that model. Literal expectations at key points pin the model.
// Works with and without CH2_4DEMUX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_ch2_4demux_tdm;

  localparam int N_CH   = 4;
  localparam int SLOT_W = 2;
`ifdef CH2_4DEMUX_PARITY_EN
  localparam int FLEN = N_CH + 1;
  localparam int SW   = SLOT_W + 1;
  localparam bit PAR  = 1'b1;
`else
  localparam int FLEN = N_CH;
  localparam int SW   = SLOT_W;
  localparam bit PAR  = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic            D;
  logic            EN;
  logic            SYNC;
  logic [N_CH-1:0] Z;
  logic            VALID;
  logic [SW-1:0]   SLOT;
  logic            LOCK;
  logic            ERR;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  ch2_4demux_tdm dut (
    .CLK   (CLK),
    .RST   (RST),
    .D     (D),
    .EN    (EN),
    .SYNC  (SYNC),
    .Z     (Z),
    .VALID (VALID),
    .SLOT  (SLOT),
    .LOCK  (LOCK),
    .ERR   (ERR)
  );

  // ---------------- reference model (frame level) ----------------
  bit              m_locked;
  int              m_pos;        // bits received in the current frame
  bit              m_bits[$];
  logic [N_CH-1:0] exp_z;
  bit              exp_valid;
  bit              exp_err;

  always @(posedge CLK or posedge RST) begin
    int ones;
    if (RST) begin
      m_locked = 1'b0;
      m_pos    = 0;
      m_bits.delete();
      exp_z     = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (EN === 1'b1) begin
        if (SYNC === 1'b1) begin
          if (m_locked && m_pos != 0) exp_err = 1'b1;
          m_bits.delete();
          m_bits.push_back(D);
          m_pos    = 1;
          m_locked = 1'b1;
        end else if (m_locked) begin
          if (m_pos == 0) begin
            exp_err  = 1'b1;
            m_locked = 1'b0;
            m_bits.delete();
          end else begin
            m_bits.push_back(D);
            m_pos++;
            if (m_pos == FLEN) begin
              ones = 0;
              foreach (m_bits[k]) ones += int'(m_bits[k]);
              if (PAR && (ones % 2 != 0)) begin
                exp_err = 1'b1;
              end else begin
                for (int k = 0; k < N_CH; k++) exp_z[k] = m_bits[k];
                exp_valid = 1'b1;
              end
              m_pos = 0;
              m_bits.delete();
            end
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_now();
    chk("model_z",     32'(Z),     32'(exp_z));
    chk("model_valid", 32'(VALID), 32'(exp_valid));
    chk("model_err",   32'(ERR),   32'(exp_err));
    chk("model_lock",  32'(LOCK),  32'(m_locked));
    chk("model_slot",  32'(SLOT),  32'(m_pos));
  endtask

  // Drive one cycle, then compare 1 time unit after the active edge.
  task automatic step(input logic e, input logic s, input logic d);
    EN   = e;
    SYNC = s;
    D    = d;
    @(posedge CLK);
    #1;
    check_now();
  endtask

  // One well-formed frame with SYNC on slot 0 and correct parity if enabled.
  task automatic send_frame(input logic [N_CH-1:0] data);
    for (int i = 0; i < N_CH; i++) step(1'b1, (i == 0), data[i]);
    if (PAR) step(1'b1, 1'b0, ^data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1; EN = 1'b0; SYNC = 1'b0; D = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_now();
    chk("rst_z",     32'(Z),     32'd0);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_slot",  32'(SLOT),  32'd0);
    chk("rst_lock",  32'(LOCK),  32'd0);
    RST = 1'b0;

    // 1: reset in the middle of a frame
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("t1_slot_mid", 32'(SLOT), 32'd2);
    RST = 1'b1;
    #2;
    check_now();
    chk("t1_rst_z",    32'(Z),     32'd0);
    chk("t1_rst_slot", 32'(SLOT),  32'd0);
    chk("t1_rst_lock", 32'(LOCK),  32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("t1_no_valid", 32'(VALID), 32'd0);
    end
    chk("t1_still_hunt", 32'(LOCK), 32'd0);

    // 2: basic frame, D = 1,0,1,1
    send_frame(4'b1101);
    chk("t2_z",     32'(Z),     32'h0000000d);
    chk("t2_valid", 32'(VALID), 32'd1);
    chk("t2_lock",  32'(LOCK),  32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("t2_valid_1cyc", 32'(VALID), 32'd0);
    chk("t2_z_hold",     32'(Z),     32'h0000000d);

    // 3: the same frame with a 3-cycle EN gap after slot 1
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("t3_gap_slot",  32'(SLOT),  32'd2);
      chk("t3_gap_valid", 32'(VALID), 32'd0);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    if (PAR) step(1'b1, 1'b0, 1'b1);
    chk("t3_z",     32'(Z),     32'h0000000d);
    chk("t3_valid", 32'(VALID), 32'd1);

    // 4: early SYNC at slot 2, then frame 0,1,1,0 from that bit
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("t4_slot2", 32'(SLOT), 32'd2);
    step(1'b1, 1'b1, 1'b0);
    chk("t4_err",    32'(ERR),   32'd1);
    chk("t4_nvalid", 32'(VALID), 32'd0);
    chk("t4_z_kept", 32'(Z),     32'h0000000d);
    chk("t4_slot1",  32'(SLOT),  32'd1);
    chk("t4_lock",   32'(LOCK),  32'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("t4_err_1cyc", 32'(ERR), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    if (PAR) step(1'b1, 1'b0, 1'b0);
    chk("t4_z",     32'(Z),     32'h00000006);
    chk("t4_valid", 32'(VALID), 32'd1);

    // 5: missing SYNC on slot 0
    step(1'b1, 1'b0, 1'b1);
    chk("t5_err",  32'(ERR),  32'd1);
    chk("t5_lock", 32'(LOCK), 32'd0);
    chk("t5_slot", 32'(SLOT), 32'd0);
    for (int i = 0; i < FLEN; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("t5_no_valid", 32'(VALID), 32'd0);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("t5_z_kept", 32'(Z), 32'h00000006);

    // back-to-back frames, no idle slot
    send_frame(4'b1010);
    chk("b2b_z1", 32'(Z),     32'h0000000a);
    chk("b2b_v1", 32'(VALID), 32'd1);
    send_frame(4'b0101);
    chk("b2b_z2", 32'(Z),     32'h00000005);
    chk("b2b_v2", 32'(VALID), 32'd1);

`ifdef CH2_4DEMUX_PARITY_EN
    // 6: good parity, then the same data with a wrong parity bit
    send_frame(4'b0110);
    chk("t6_z0", 32'(Z), 32'h00000006);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("t6_perr",  32'(ERR),   32'd1);
    chk("t6_pnval", 32'(VALID), 32'd0);
    chk("t6_pz",    32'(Z),     32'h00000006);
    chk("t6_plock", 32'(LOCK),  32'd1);
    send_frame(4'b1101);
    chk("t6_z",     32'(Z),     32'h0000000d);
    chk("t6_valid", 32'(VALID), 32'd1);
`endif

    step(1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ch2_4demux_tdm
